// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding,
// frame layout constants and small combinational helpers.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loaderState_t;

  // Header count and payload words are both four little-endian bytes, so one
  // packer serves both phases.
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

  // Running XOR checksum over payload bytes.
  function automatic logic [7:0] csumUpdate(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // States in which the loader consumes stream bytes (and counts as busy).
  function automatic logic inFrame(input loaderState_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte packer. Collects three bytes in registered lanes and
// presents the complete word combinationally in the cycle its fourth byte
// arrives, so the owner can act on it (and register it) on that same edge.
// A byte arriving in the following cycle starts the next word cleanly.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byteValid,
  input  logic [7:0]  byteIn,
  output logic        wordValid,
  output logic [31:0] word
);

  logic [1:0]  idx_r;
  logic [23:0] lanes_r;

  // Byte index counter; wraps after the last byte of each word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= 2'd0;
    end else if (clear) begin
      idx_r <= 2'd0;
    end else if (byteValid) begin
      idx_r <= idx_r + 2'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Lower three byte lanes; the top byte is taken straight from the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_r <= 24'd0;
    end else if (clear) begin
      lanes_r <= 24'd0;
    end else if (byteValid) begin
      case (idx_r)
        2'd0:    lanes_r[7:0]   <= byteIn;
        2'd1:    lanes_r[15:8]  <= byteIn;
        2'd2:    lanes_r[23:16] <= byteIn;
        default: lanes_r        <= lanes_r;
      endcase
    end else begin
      lanes_r <= lanes_r;
    end
  end

  // Completed-word view: valid with the byte that finishes the word.
  always_comb begin
    wordValid = 1'b0;
    word      = {byteIn, lanes_r};
    if (byteValid && (idx_r == LAST_BYTE_IDX)) begin
      wordValid = 1'b1;
    end else begin
      wordValid = 1'b0;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream (count, payload
// words, XOR checksum), writes the payload into iMem from word 0 and releases
// the core reset only after the checksum verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [31:0]   MAX_WORDS_W = 32'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

  loaderState_t     state_r;
  loaderState_t     stateNext_s;
  logic             startAcc_s;
  logic             xfer_s;
  logic             pkValid_s;
  logic [31:0]      pkWord_s;
  logic [ADDR_W:0]  wordTotal_r;
  logic [ADDR_W:0]  wordCnt_r;
  logic [7:0]       csum_r;
  logic             lastWord_s;

  assign xfer_s     = rx_valid & rx_ready;
  assign lastWord_s = (wordCnt_r == (wordTotal_r - ONE_CNT));

  byte_packer uPacker (
    .clk       (clk),
    .rst       (rst),
    .clear     (startAcc_s),
    .byteValid (xfer_s),
    .byteIn    (rx_data),
    .wordValid (pkValid_s),
    .word      (pkWord_s)
  );

  // Next-state logic; start is honoured only outside a frame.
  always_comb begin
    stateNext_s = state_r;
    startAcc_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          stateNext_s = ST_HDR;
          startAcc_s  = 1'b1;
        end else begin
          stateNext_s = state_r;
        end
      end
      ST_HDR: begin
        if (pkValid_s) begin
          if (pkWord_s == 32'd0) begin
            stateNext_s = ST_CSUM;
          end else if (pkWord_s > MAX_WORDS_W) begin
            stateNext_s = ST_ERR;
          end else begin
            stateNext_s = ST_DATA;
          end
        end else begin
          stateNext_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (pkValid_s && lastWord_s) begin
          stateNext_s = ST_CSUM;
        end else begin
          stateNext_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (xfer_s) begin
          if (rx_data == csum_r) begin
            stateNext_s = ST_DONE;
          end else begin
            stateNext_s = ST_ERR;
          end
        end else begin
          stateNext_s = ST_CSUM;
        end
      end
      default: begin
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Status outputs registered from the next state so they line up with it;
  // core reset is released one cycle after DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      rx_ready   <= inFrame(stateNext_s);
      busy       <= inFrame(stateNext_s);
      done       <= (stateNext_s == ST_DONE);
      err        <= (stateNext_s == ST_ERR);
      core_rst_n <= (state_r == ST_DONE) && (stateNext_s == ST_DONE);
    end
  end

  // Image length captured from the completed header word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordTotal_r <= '0;
    end else if ((state_r == ST_HDR) && pkValid_s) begin
      wordTotal_r <= pkWord_s[ADDR_W:0];
    end else begin
      wordTotal_r <= wordTotal_r;
    end
  end

  // Count of payload words written so far; doubles as the next iMem address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordCnt_r <= '0;
    end else if (startAcc_s) begin
      wordCnt_r <= '0;
    end else if ((state_r == ST_DATA) && pkValid_s) begin
      wordCnt_r <= wordCnt_r + ONE_CNT;
    end else begin
      wordCnt_r <= wordCnt_r;
    end
  end

  // XOR over payload bytes only; header and checksum bytes are excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_r <= 8'd0;
    end else if (startAcc_s) begin
      csum_r <= 8'd0;
    end else if ((state_r == ST_DATA) && xfer_s) begin
      csum_r <= csumUpdate(csum_r, rx_data);
    end else begin
      csum_r <= csum_r;
    end
  end

  // iMem write port: one-cycle strobe from a registered copy of the word,
  // address held between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else if (startAcc_s) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= imem_wdata;
    end else if ((state_r == ST_DATA) && pkValid_s) begin
      imem_we    <= 1'b1;
      imem_addr  <= wordCnt_r[ADDR_W-1:0];
      imem_wdata <= pkWord_s;
    end else begin
      imem_we    <= 1'b0;
      imem_addr  <= imem_addr;
      imem_wdata <= imem_wdata;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: frames are built from the
// framing rules, expected iMem writes are queued as bytes are issued and an
// independent monitor pops and compares each write strobe.
module tb_prog_loader;

  localparam int TB_ADDR_W = 10;
  localparam int TB_MAX    = 1024;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic                 imem_we;
  logic [TB_ADDR_W-1:0] imem_addr;
  logic [31:0]          imem_wdata;
  logic                 core_rst_n;
  logic                 busy;
  logic                 done;
  logic                 err;

  int total = 0;
  int bad   = 0;
  int writesSeen = 0;
  bit prevWe = 1'b0;

  logic [TB_ADDR_W+31:0] expQ[$];
  logic [31:0]           frameWords[$];

  prog_loader #(.ADDR_W(TB_ADDR_W), .MAX_WORDS(TB_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must be a single cycle and match the queue head.
  always @(negedge clk) begin
    logic [TB_ADDR_W+31:0] e;
    if (imem_we === 1'b1) begin
      writesSeen++;
      total++;
      if (prevWe) begin
        bad++;
        $display("FAIL we_pulse: strobe high on consecutive cycles addr=%0h", imem_addr);
      end
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h want none", imem_addr, imem_wdata);
      end else begin
        e = expQ.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%0h want addr=%0h data=%0h",
                   imem_addr, imem_wdata, e[TB_ADDR_W+31:32], e[31:0]);
        end
      end
    end
    prevWe = (imem_we === 1'b1);
  end

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte (optionally after a random idle gap) until it is accepted.
  task automatic sendByte(input logic [7:0] b, input bit gaps, input bit withStart);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = withStart;
    guard    = 0;
    while (!rx_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 want 1 within 50 cycles");
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // One complete load. Expected outcome follows from the framing rules alone.
  task automatic runFrame(input logic [31:0] nCount, input bit doStart, input bit gaps,
                          input bit badCsum, input int startAtByte);
    logic [7:0]  x;
    logic [31:0] w;
    int          byteNo;
    int          startWrites;
    bit          oversize;
    bit          expOk;
    logic [TB_ADDR_W-1:0] a;
    x = 8'd0;
    byteNo = 0;
    oversize = (nCount > 32'(TB_MAX));
    startWrites = writesSeen;
    if (doStart) pulseStart();
    for (int i = 0; i < 4; i++) sendByte(nCount[8*i +: 8], gaps, 1'b0);
    if (!oversize) begin
      for (int k = 0; k < int'(nCount); k++) begin
        w = frameWords[k];
        a = TB_ADDR_W'(k);
        expQ.push_back({a, w});
        for (int b = 0; b < 4; b++) begin
          x = x ^ w[8*b +: 8];
          sendByte(w[8*b +: 8], gaps, byteNo == startAtByte);
          byteNo++;
        end
      end
      sendByte(x ^ {7'd0, badCsum}, gaps, 1'b0);
      expOk = !badCsum;
    end else begin
      expOk = 1'b0;
    end
    check("done", done, expOk);
    check("err", err, !expOk);
    check("busy_end", busy, 1'b0);
    check("rx_ready_end", rx_ready, 1'b0);
    check("core_rst_n_entry", core_rst_n, 1'b0);
    @(posedge clk); #1;
    check("core_rst_n_after", core_rst_n, expOk);
    check("pending_writes", expQ.size(), 0);
    check("write_count", writesSeen - startWrites, oversize ? 0 : int'(nCount));
  endtask

  task automatic randomWords(input int n);
    frameWords.delete();
    for (int k = 0; k < n; k++) frameWords.push_back($urandom);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_core_rst_n", core_rst_n, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-instruction image.
    frameWords.delete();
    frameWords.push_back(32'h00500093);
    frameWords.push_back(32'h00A00113);
    runFrame(32'd2, 1'b1, 1'b0, 1'b0, -1);

    // Empty image, good then bad checksum.
    runFrame(32'd0, 1'b1, 1'b1, 1'b0, -1);
    runFrame(32'd0, 1'b1, 1'b0, 1'b1, -1);

    // Oversized count rejected after the header.
    runFrame(32'h401, 1'b1, 1'b1, 1'b0, -1);

    // Same N=3 image streamed back-to-back and with random gaps.
    randomWords(3);
    runFrame(32'd3, 1'b1, 1'b0, 1'b0, -1);
    runFrame(32'd3, 1'b1, 1'b1, 1'b0, -1);

    // Reset in the middle of word 1 of a four-word image.
    randomWords(4);
    pulseStart();
    for (int i = 0; i < 4; i++) sendByte(8'(i == 0 ? 4 : 0), 1'b0, 1'b0);
    expQ.push_back({TB_ADDR_W'(0), frameWords[0]});
    for (int b = 0; b < 4; b++) sendByte(frameWords[0][8*b +: 8], 1'b0, 1'b0);
    sendByte(frameWords[1][7:0], 1'b0, 1'b0);
    sendByte(frameWords[1][15:8], 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rx_ready", rx_ready, 1'b0);
    check("mid_rst_we", imem_we, 1'b0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_wdata", imem_wdata, 0);
    check("mid_rst_core_rst_n", core_rst_n, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pending", expQ.size(), 0);
    n = writesSeen;
    rx_valid = 1'b1;
    repeat (4) begin
      rx_data = 8'($urandom);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    repeat (6) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    check("mid_rst_no_writes", writesSeen - n, 0);
    check("mid_rst_idle_done", done, 1'b0);
    randomWords(1);
    runFrame(32'd1, 1'b1, 1'b1, 1'b0, -1);

    // start during DATA is ignored; start in DONE restarts cleanly.
    randomWords(2);
    runFrame(32'd2, 1'b1, 1'b0, 1'b0, 5);
    pulseStart();
    check("restart_core_rst_n", core_rst_n, 1'b0);
    check("restart_done", done, 1'b0);
    check("restart_busy", busy, 1'b1);
    check("restart_rx_ready", rx_ready, 1'b1);
    runFrame(32'd0, 1'b0, 1'b0, 1'b0, -1);

    // Random images with occasional corrupted checksum.
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 6);
      randomWords(n);
      runFrame(32'(n), 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), -1);
    end

    // Largest accepted image, covering the full address range.
    randomWords(TB_MAX);
    runFrame(32'(TB_MAX), 1'b1, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
